// File: rtl/fmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: iterative 24x24 shift-add
// significand product, then normalize, round-to-nearest-even and pack.
module fmul_seq #(
  parameter int unsigned EXP_BIAS = 127,
  parameter int unsigned EXP_MAX  = 255,
  parameter logic [31:0] QNAN     = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0]        EXP_ONES = EXP_MAX[7:0];
  localparam logic [9:0]        BIAS10   = EXP_BIAS[9:0];
  localparam logic signed [9:0] EMAX10   = EXP_MAX[9:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        sign_r, sign_s;
  logic [7:0]  ea_r, ea_s, eb_r, eb_s;
  logic [23:0] mcand_r, mcand_s, mplier_r, mplier_s;
  logic [47:0] acc_r, acc_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [31:0] result_r, result_s;
  logic        invalid_r, invalid_s, overflow_r, overflow_s, underflow_r, underflow_s;
  logic        out_valid_r, out_valid_s, in_ready_r, in_ready_s;

  // Operand classification; exp==0 means zero, so denormal inputs flush to zero.
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic any_nan_s, any_inf_s, any_zero_s, special_s;
  assign a_zero_s   = (a[30:23] == 8'd0);
  assign b_zero_s   = (b[30:23] == 8'd0);
  assign a_inf_s    = (a[30:23] == EXP_ONES) && (a[22:0] == 23'd0);
  assign b_inf_s    = (b[30:23] == EXP_ONES) && (b[22:0] == 23'd0);
  assign a_nan_s    = (a[30:23] == EXP_ONES) && (a[22:0] != 23'd0);
  assign b_nan_s    = (b[30:23] == EXP_ONES) && (b[22:0] != 23'd0);
  assign any_nan_s  = a_nan_s | b_nan_s;
  assign any_inf_s  = a_inf_s | b_inf_s;
  assign any_zero_s = a_zero_s | b_zero_s;
  assign special_s  = any_nan_s | any_inf_s | any_zero_s;

  // One shift-add step: add multiplicand to the upper half, then shift right.
  logic [24:0] partial_s, sum_s;
  assign partial_s = mplier_r[0] ? {1'b0, mcand_r} : 25'd0;
  assign sum_s     = {1'b0, acc_r[47:24]} + partial_s;

  logic [22:0] mant_s, mant_fin_s;
  logic        guard_s, sticky_s, round_up_s;
  logic [23:0] mant_rnd_s;
  logic [1:0]  exp_adj_s;
  logic [9:0]  exp_s;
  logic        exp_ovf_s, exp_unf_s;
  assign mant_s     = acc_r[47] ? acc_r[46:24] : acc_r[45:23];
  assign guard_s    = acc_r[47] ? acc_r[23] : acc_r[22];
  assign sticky_s   = acc_r[47] ? (|acc_r[22:0]) : (|acc_r[21:0]);
  assign round_up_s = guard_s & (sticky_s | mant_s[0]);
  assign mant_rnd_s = {1'b0, mant_s} + {23'd0, round_up_s};
  // A rounding carry-out leaves an all-zero fraction one binade up.
  assign mant_fin_s = mant_rnd_s[23] ? 23'd0 : mant_rnd_s[22:0];
  assign exp_adj_s  = {1'b0, acc_r[47]} + {1'b0, mant_rnd_s[23]};
  assign exp_s      = {2'b00, ea_r} + {2'b00, eb_r} - BIAS10 + {8'd0, exp_adj_s};
  assign exp_ovf_s  = ($signed(exp_s) >= EMAX10);
  assign exp_unf_s  = ($signed(exp_s) <= 10'sd0);

  // Next-state and datapath update for the four-state sequencer.
  always_comb begin
    state_s     = state_r;
    sign_s      = sign_r;
    ea_s        = ea_r;
    eb_s        = eb_r;
    mcand_s     = mcand_r;
    mplier_s    = mplier_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    result_s    = result_r;
    invalid_s   = invalid_r;
    overflow_s  = overflow_r;
    underflow_s = underflow_r;
    out_valid_s = out_valid_r;
    in_ready_s  = in_ready_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_s      = a[31] ^ b[31];
          ea_s        = a[30:23];
          eb_s        = b[30:23];
          mcand_s     = {1'b1, a[22:0]};
          mplier_s    = {1'b1, b[22:0]};
          acc_s       = 48'd0;
          cnt_s       = 5'd23;
          invalid_s   = 1'b0;
          overflow_s  = 1'b0;
          underflow_s = 1'b0;
          in_ready_s  = 1'b0;
          if (special_s) begin
            state_s     = DONE;
            out_valid_s = 1'b1;
            if (any_nan_s || (any_zero_s && any_inf_s)) begin
              result_s  = QNAN;
              invalid_s = 1'b1;
            end else if (any_inf_s) begin
              result_s = {a[31] ^ b[31], EXP_ONES, 23'd0};
            end else begin
              result_s = {a[31] ^ b[31], 31'd0};
            end
          end else begin
            state_s = MUL;
          end
        end else begin
          in_ready_s = 1'b1;
        end
      end
      MUL: begin
        acc_s    = {sum_s, acc_r[23:1]};
        mplier_s = {1'b0, mplier_r[23:1]};
        if (cnt_r == 5'd0) begin
          state_s = NORM;
        end else begin
          cnt_s = cnt_r - 5'd1;
        end
      end
      NORM: begin
        state_s     = DONE;
        out_valid_s = 1'b1;
        if (exp_ovf_s) begin
          result_s   = {sign_r, EXP_ONES, 23'd0};
          overflow_s = 1'b1;
        end else if (exp_unf_s) begin
          result_s    = {sign_r, 31'd0};
          underflow_s = 1'b1;
        end else begin
          result_s = {sign_r, exp_s[7:0], mant_fin_s};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
          invalid_s   = 1'b0;
          overflow_s  = 1'b0;
          underflow_s = 1'b0;
          in_ready_s  = 1'b1;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sign_r      <= 1'b0;
      ea_r        <= 8'd0;
      eb_r        <= 8'd0;
      mcand_r     <= 24'd0;
      mplier_r    <= 24'd0;
      acc_r       <= 48'd0;
      cnt_r       <= 5'd0;
      result_r    <= 32'd0;
      invalid_r   <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      sign_r      <= sign_s;
      ea_r        <= ea_s;
      eb_r        <= eb_s;
      mcand_r     <= mcand_s;
      mplier_r    <= mplier_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      invalid_r   <= invalid_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign result    = result_r;
  assign invalid   = invalid_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fmul_seq.sv
// Scoreboard bench for fmul_seq: expected results are queued when operands are
// driven and compared when out_valid appears.
module tb_fmul_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, invalid, overflow, underflow, out_valid;
  logic [31:0] result;

  fmul_seq dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .invalid(invalid), .overflow(overflow), .underflow(underflow),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference model: {invalid, overflow, underflow, result}
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, xz, yz, xi, yi, xn, yn;
    logic [47:0] sx, sy, p;
    logic [23:0] m;
    logic        g, st;
    int          adj, e;
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00); yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (xn || yn || ((xz || yz) && (xi || yi))) return {3'b100, 32'h7FC00000};
    if (xi || yi) return {3'b000, s, 8'hFF, 23'd0};
    if (xz || yz) return {3'b000, s, 31'd0};
    sx = {24'd0, 1'b1, x[22:0]};
    sy = {24'd0, 1'b1, y[22:0]};
    p  = sx * sy;
    if (p[47]) begin m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; adj = 1; end
    else       begin m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0]; adj = 0; end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin adj = adj + 1; m = 24'd0; end
    e = int'(x[30:23]) + int'(y[30:23]) - 127 + adj;
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b001, s, 31'd0};
    return {3'b000, s, e[7:0], m[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_res, input logic [2:0] exp_flg,
                        input int exp_lat, input int hold);
    exp_t        e;
    int          n;
    logic        ready_bad, stable;
    logic [31:0] held;
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    a = op_a; b = op_b; in_valid = 1'b1; out_ready = (hold == 0);
    e.res = exp_res; e.flg = exp_flg; e.lat = exp_lat;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = 32'd0; b = 32'd0;
    n = 1; ready_bad = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) ready_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (in_ready) ready_bad = 1'b1;
    e = sb_q.pop_front();
    check("latency", n, e.lat);
    check("busy_ready", ready_bad, 0);
    check("result", result, e.res);
    check("flags", {invalid, overflow, underflow}, e.flg);
    if (hold > 0) begin
      held = result; stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || in_ready || result !== held) stable = 1'b0;
      end
      check("hold_stable", stable, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("handoff_valid", out_valid, 0);
    check("handoff_ready", in_ready, 1);
    check("flags_clear", {invalid, overflow, underflow}, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [34:0] r;
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {invalid, overflow, underflow}, 0);
    rst = 1'b0;

    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 0);
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26, 0);
    run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 26, 0);
    run_op(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 1, 0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1, 0);
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1, 0);
    run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 26, 0);
    run_op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 26, 0);
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, 3'b000, 1, 0);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1, 0);
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 10);

    // Abort mid-multiply with reset, then confirm a clean restart.
    @(negedge clk);
    a = 32'h40000000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_ready", in_ready, 1);
    check("abort_result", result, 0);
    repeat (30) @(negedge clk);
    check("abort_no_output", out_valid, 0);
    run_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 26, 0);

    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      rb = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      r  = ref_mul(ra, rb);
      run_op(ra, rb, r[31:0], r[34:32], 26, i % 3);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
